microsequencer: RTL and testbench
=================================

Name: microsequencer

Overview:
Microprogram sequencer that owns the control address register (CAR) and drives the address input of the microcode control store. Each cycle it takes the returned control word (CBR) and chooses the next address: increment, opcode dispatch, return to fetch, or a hold while waiting for memory. It gates the control word to the datapath strobes. It sits between the control store, the IR opcode field and the memory interface.

Parameters:
N, 7, CAR width (control store depth 2**N)
SZ, 23, control word width
OPW, 4, opcode width from IR
SLOT, 4, microwords per instruction slot
FETCH_ADDR, 0, fetch routine start address
WMFC_BIT, 8, control-word bit: wait for memory function complete
SEL_DEC_BIT, 21, control-word bit: dispatch on opcode
END_BIT, SZ-1, control-word bit: end of instruction
HOLD_MASK, SZ'h000300, control bits still driven during a memory wait (rnw, WMFC)
TMO, 255, maximum wait cycles before timeout; 0 disables the timeout

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
cbr  in  SZ  control word returned combinationally by the control store for the current car
opcode  in  OPW  IR opcode field, sampled on dispatch
mfc  in  1  memory function complete
hold  in  1  external stall (debug/step)
car  out  N  control address to the control store
ctrl_word  out  SZ  gated control word to the datapath
ctrl_en  out  1  ctrl_word carries a full executing microword this cycle
waiting  out  1  in the WAIT state
instr_done  out  1  one-cycle pulse when an END microword executes
err_tmo  out  1  sticky: memory wait timed out
err_wrap  out  1  sticky: car incremented past 2**N-1

Behaviour:
- Clock is clk. Reset is asynchronous and active-low on rst_n.
- Reset (async assert): car=FETCH_ADDR, state=IDLE, wait counter=0. ctrl_word, ctrl_en, waiting, instr_done, err_tmo and err_wrap are all 0. Errors clear only on reset.
- States: IDLE, RUN, WAIT.
- IDLE:
  - ctrl_en=0, ctrl_word=0.
  - Go to RUN on the next edge if hold=0.
- RUN with hold=1: ctrl_en=0, ctrl_word=0, car held.
- RUN with hold=0: ctrl_en=1, ctrl_word=cbr. The next car is chosen in this priority order:
  1. WMFC set and mfc=0: go to WAIT, car held, wait counter=1.
  2. END set: car=FETCH_ADDR, instr_done=1 for this cycle.
  3. SEL_DEC set: car = SLOT*(opcode+1), computed at N bits.
  4. Otherwise: car=car+1. From 2**N-1 it wraps to 0 and sets err_wrap.
  - If WMFC and mfc are both high in the same cycle, steps 2-4 apply immediately (zero-wait).
- WAIT:
  - ctrl_en=0, waiting=1, ctrl_word=cbr & HOLD_MASK.
  - hold is ignored.
  - On mfc=1: apply steps 2-4 to the held cbr, return to RUN, ctrl_en=0 in that cycle.
  - Else, if TMO!=0 and the counter equals TMO: set err_tmo, car=FETCH_ADDR, go to RUN.
  - Else increment the wait counter.
- Elaboration check: (2**OPW+1)*SLOT <= 2**N.
- car is the registered output; ctrl_word is combinational from cbr, state and hold.
- Reset mid-WAIT or mid-instruction aborts immediately, with no completion pulse.

Decomposition:
- Package ucode_pkg:
  - control-bit indices: add..end, pc_out, increment, WMFC, rnw, register in/out strobes, MAR_in, MBR_out, IR_in, select_decoder
  - SLOT and FETCH_ADDR
  - state enum {IDLE, RUN, WAIT}
  - dispatch-address function
- One sub-module, mfc_timeout_ctr: wait counter with load, increment and expiry compare against TMO.

Test Plan:
- Fetch with 3-cycle memory wait: release reset with hold=0 and fetch microcode loaded (word0 pc_out|increment|MAR_in; word1 rnw|WMFC; word2 MBR_out|IR_in|select_decoder); mfc rises on the 3rd WAIT cycle; opcode=4'h3 -> car sequence 0(IDLE),0,1,1,1,1,2,16; ctrl_word=0x000300 while waiting=1; ctrl_en=0 in IDLE and WAIT.
- Zero-wait: mfc=1 during word1 -> car goes 1->2 on the next edge; waiting never asserts.
- Instruction end: car=17, cbr has bit 22 set -> next car=0; instr_done high exactly 1 cycle.
- Timeout: TMO=8, mfc held 0 at word1 -> after 8 WAIT cycles err_tmo=1, car=0, state RUN; err_tmo stays 1.
- Wrap: car=127, cbr has no flags -> car=0, err_wrap=1. Also, opcode=4'hF dispatch -> car=64.
- Reset mid-WAIT: rst_n low asynchronously -> car=0 and errors cleared without a clock edge. Also, hold=1 during RUN -> car frozen and ctrl_word=0 until hold=0.

Source files
------------

// File: rtl/ucode_pkg.sv
// ucode_pkg: control-word bit map, slot layout, sequencer states and the dispatch map.
package ucode_pkg;
  localparam int CB_ADD      = 0;
  localparam int CB_PC_OUT   = 1;
  localparam int CB_INC      = 2;
  localparam int CB_MAR_IN   = 3;
  localparam int CB_MBR_OUT  = 4;
  localparam int CB_IR_IN    = 5;
  localparam int CB_WMFC     = 8;
  localparam int CB_RNW      = 9;
  localparam int CB_REG_IN   = 10;
  localparam int CB_REG_OUT  = 15;
  localparam int CB_SEL_DEC  = 21;
  localparam int CB_END      = 22;
  localparam int SLOT        = 4;
  localparam int FETCH_ADDR  = 0;
  typedef enum logic [1:0] {IDLE, RUN, WAIT} state_t;
  // slot 0 holds the fetch routine, so opcode k starts at slot k+1
  function automatic int dispatch_addr(input int opc);
    return SLOT * (opc + 1);
  endfunction
endpackage

// File: rtl/mfc_timeout_ctr.sv
// mfc_timeout_ctr: counts memory-wait cycles and flags when the wait limit is reached.
module mfc_timeout_ctr #(
  parameter int TMO = 255,
  parameter int W = (TMO > 0) ? $clog2(TMO + 1) : 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic inc,
  output logic expired
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= W'(1);
    else if (inc) cnt <= cnt + W'(1);
  assign expired = (TMO != 0) && (cnt == W'(TMO));
endmodule

// File: rtl/microsequencer.sv
// microsequencer: owns the control address register and gates control words to the datapath.
module microsequencer
  import ucode_pkg::*;
#(
  parameter int N = 7,
  parameter int SZ = 23,
  parameter int OPW = 4,
  parameter int WMFC_BIT = CB_WMFC,
  parameter int SEL_DEC_BIT = CB_SEL_DEC,
  parameter int END_BIT = SZ - 1,
  parameter logic [SZ-1:0] HOLD_MASK = SZ'('h300),
  parameter int TMO = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [SZ-1:0] cbr,
  input  logic [OPW-1:0] opcode,
  input  logic          mfc,
  input  logic          hold,
  output logic [N-1:0]  car,
  output logic [SZ-1:0] ctrl_word,
  output logic          ctrl_en,
  output logic          waiting,
  output logic          instr_done,
  output logic          err_tmo,
  output logic          err_wrap
);
  if ((2**OPW + 1) * SLOT > 2**N) begin : g_chk
    $error("control store too small for opcode dispatch");
  end
  state_t state, state_n;
  logic [N-1:0] car_n, seq_car;
  logic wrap, set_wrap, set_tmo, load, inc, expired;
  mfc_timeout_ctr #(.TMO(TMO)) u_tmo (
    .clk(clk), .rst_n(rst_n), .load(load), .inc(inc), .expired(expired)
  );
  assign seq_car = cbr[END_BIT] ? N'(FETCH_ADDR)
                 : cbr[SEL_DEC_BIT] ? N'(dispatch_addr(int'(opcode)))
                 : car + N'(1);
  assign wrap = !cbr[END_BIT] && !cbr[SEL_DEC_BIT] && (&car);
  assign waiting = (state == WAIT);
  always_comb begin
    state_n = state;
    car_n = car;
    ctrl_word = '0;
    ctrl_en = 1'b0;
    instr_done = 1'b0;
    set_wrap = 1'b0;
    set_tmo = 1'b0;
    load = 1'b0;
    inc = 1'b0;
    case (state)
      IDLE: state_n = hold ? IDLE : RUN;
      RUN: if (!hold) begin
        ctrl_en = 1'b1;
        ctrl_word = cbr;
        if (cbr[WMFC_BIT] && !mfc) begin
          state_n = WAIT;
          load = 1'b1;
        end else begin
          car_n = seq_car;
          set_wrap = wrap;
          instr_done = cbr[END_BIT];
        end
      end
      WAIT: begin
        // only the bus-request bits stay asserted while memory finishes
        ctrl_word = cbr & HOLD_MASK;
        if (mfc) begin
          state_n = RUN;
          car_n = seq_car;
          set_wrap = wrap;
          instr_done = cbr[END_BIT];
        end else if (expired) begin
          state_n = RUN;
          car_n = N'(FETCH_ADDR);
          set_tmo = 1'b1;
        end else inc = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      car <= N'(FETCH_ADDR);
      err_tmo <= 1'b0;
      err_wrap <= 1'b0;
    end else begin
      state <= state_n;
      car <= car_n;
      err_tmo <= err_tmo | set_tmo;
      err_wrap <= err_wrap | set_wrap;
    end
endmodule

// File: tb/tb_microsequencer.sv
// tb_microsequencer: directed fetch/dispatch/wait/timeout/wrap/reset run against a behavioural model.
module tb_microsequencer;
  logic clk = 1'b0, rst_n = 1'b0, mfc = 1'b0, hold = 1'b0;
  logic [3:0] opcode = 4'h0;
  logic [22:0] cbr, ctrl_word;
  logic [6:0] car;
  logic ctrl_en, waiting, instr_done, err_tmo, err_wrap;
  logic [22:0] rom [128];
  int total = 0, bad = 0;
  int m_state = 0, m_car = 0, m_cnt = 0;
  bit m_tmo = 1'b0, m_wrap = 1'b0;

  always #5 clk = ~clk;
  assign cbr = rom[car];

  microsequencer #(.TMO(8)) dut (
    .clk(clk), .rst_n(rst_n), .cbr(cbr), .opcode(opcode), .mfc(mfc), .hold(hold),
    .car(car), .ctrl_word(ctrl_word), .ctrl_en(ctrl_en), .waiting(waiting),
    .instr_done(instr_done), .err_tmo(err_tmo), .err_wrap(err_wrap)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // model: states 0=idle 1=run 2=wait; addresses are plain integers mod 128
  task automatic advance(input logic [22:0] w);
    if (!w[22] && !w[21] && m_car == 127) m_wrap = 1'b1;
    m_car = w[22] ? 0 : w[21] ? (4 * (int'(opcode) + 1)) % 128 : (m_car + 1) % 128;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = 0; m_car = 0; m_cnt = 0; m_tmo = 1'b0; m_wrap = 1'b0;
    end else if (m_state == 0) begin
      if (!hold) m_state = 1;
    end else if (m_state == 1) begin
      if (!hold) begin
        if (rom[m_car][8] && !mfc) begin m_state = 2; m_cnt = 1; end
        else advance(rom[m_car]);
      end
    end else begin
      if (mfc) begin advance(rom[m_car]); m_state = 1; end
      else if (m_cnt == 8) begin m_tmo = 1'b1; m_car = 0; m_state = 1; end
      else m_cnt++;
    end
  end

  always @(negedge clk) begin
    logic [22:0] w, e_word;
    logic run, e_done;
    w = rom[m_car];
    run = (m_state == 1) && !hold;
    e_word = run ? w : (m_state == 2) ? (w & 23'h000300) : 23'h0;
    e_done = w[22] && ((run && !(w[8] && !mfc)) || (m_state == 2 && mfc));
    check("car", 32'(car), 32'(m_car));
    check("ctrl_word", 32'(ctrl_word), 32'(e_word));
    check("ctrl_en", 32'(ctrl_en), 32'(run));
    check("waiting", 32'(waiting), 32'(m_state == 2));
    check("instr_done", 32'(instr_done), 32'(e_done));
    check("err_tmo", 32'(err_tmo), 32'(m_tmo));
    check("err_wrap", 32'(err_wrap), 32'(m_wrap));
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) rom[i] = 23'h0;
    rom[0] = 23'h00000E;
    rom[1] = 23'h000300;
    rom[2] = 23'h200030;
    rom[16] = 23'h000001;
    rom[17] = 23'h400400;
    opcode = 4'h3;
    #12 rst_n = 1'b1;
    check("rst_car", 32'(car), 32'd0);
    check("rst_en", 32'(ctrl_en), 32'd0);
    check("rst_word", 32'(ctrl_word), 32'd0);
    check("rst_errs", 32'({err_tmo, err_wrap}), 32'd0);
    step(); check("f_run_car", 32'(car), 32'd0); check("f_run_en", 32'(ctrl_en), 32'd1);
    step(); check("f_w1_car", 32'(car), 32'd1);
    step(); check("f_wait_car", 32'(car), 32'd1); check("f_wait_word", 32'(ctrl_word), 32'h300);
    check("f_wait_en", 32'(ctrl_en), 32'd0); check("f_waiting", 32'(waiting), 32'd1);
    step(); check("f_wait2", 32'(waiting), 32'd1);
    step(); mfc = 1'b1; check("f_wait3", 32'(waiting), 32'd1); check("f_rel_en", 32'(ctrl_en), 32'd0);
    step(); mfc = 1'b0; check("f_w2_car", 32'(car), 32'd2); check("f_w2_wait", 32'(waiting), 32'd0);
    step(); check("disp3_car", 32'(car), 32'd16);
    step(); check("end_car", 32'(car), 32'd17); check("end_done", 32'(instr_done), 32'd1);
    step(); check("end_ret", 32'(car), 32'd0); check("end_pulse", 32'(instr_done), 32'd0);
    step(); check("zw_car1", 32'(car), 32'd1); mfc = 1'b1;
    check("zw_nowait", 32'(waiting), 32'd0);
    step(); mfc = 1'b0; check("zw_car2", 32'(car), 32'd2); check("zw_waiting", 32'(waiting), 32'd0);
    opcode = 4'hF;
    step(); check("dispF_car", 32'(car), 32'd64);
    repeat (63) step();
    check("top_car", 32'(car), 32'd127); check("top_wrap", 32'(err_wrap), 32'd0);
    step(); check("wrap_car", 32'(car), 32'd0); check("wrap_err", 32'(err_wrap), 32'd1);
    hold = 1'b1;
    repeat (3) step();
    check("hold_car", 32'(car), 32'd0); check("hold_word", 32'(ctrl_word), 32'd0);
    check("hold_en", 32'(ctrl_en), 32'd0);
    hold = 1'b0;
    step(); check("tmo_w1", 32'(car), 32'd1);
    step(); check("tmo_wait", 32'(waiting), 32'd1);
    repeat (7) step();
    check("tmo_still", 32'(waiting), 32'd1); check("tmo_pre", 32'(err_tmo), 32'd0);
    step(); check("tmo_car", 32'(car), 32'd0); check("tmo_err", 32'(err_tmo), 32'd1);
    check("tmo_run", 32'(waiting), 32'd0);
    step(); step(); check("tmo_sticky", 32'(err_tmo), 32'd1); check("rw_wait", 32'(waiting), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_car", 32'(car), 32'd0); check("ar_tmo", 32'(err_tmo), 32'd0);
    check("ar_wrap", 32'(err_wrap), 32'd0); check("ar_wait", 32'(waiting), 32'd0);
    check("ar_done", 32'(instr_done), 32'd0);
    #8 rst_n = 1'b1;
    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
